// File: rtl/watch_alarm_core.sv
// Watch core: 1 Hz prescaler, HH:MM:SS time counter, button-driven edit FSM,
// 12/24-hour display mapping and a single alarm with timed ring.
module watch_alarm_core #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int RING_SECS   = 60,
  parameter int AL_HOUR_RST = 7,
  parameter int AL_MIN_RST  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       fmt_12h,
  input  logic       alarm_en,
  output logic       en_1hz,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       pm,
  output logic [2:0] edit_state,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       alarm_ring
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int RW = (RING_SECS > 0) ? $clog2(RING_SECS + 1) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_FREQ - 1);
  localparam logic [RW-1:0] RING_LD = RW'(RING_SECS);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    SET_SEC = 3'd3,
    AL_HR   = 3'd4,
    AL_MIN  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          en_q, en_d;
  logic [4:0]    hr_q, hr_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [4:0]    alh_q, alh_d;
  logic [5:0]    alm_q, alm_d;
  logic          ring_q, ring_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  logic       inc;
  logic       cancel;
  logic       trigger;
  logic [4:0] hr_nx;
  logic [5:0] min_nx;
  logic [5:0] sec_nx;

  // Time as it will be after one tick; used by both the counter and the alarm compare.
  always_comb begin
    sec_nx = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
    min_nx = min_q;
    hr_nx  = hr_q;
    if (sec_q == 6'd59) begin
      min_nx = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      if (min_q == 6'd59) hr_nx = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
    end
  end

  // mode_btn has priority, so a coincident inc_btn is dropped.
  assign inc     = inc_btn & ~mode_btn;
  assign cancel  = mode_btn | inc_btn | ~alarm_en;
  assign trigger = (state_q == RUN) && alarm_en && en_q &&
                   (hr_nx == alh_q) && (min_nx == alm_q) && (sec_nx == 6'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mode_btn) state_d = SET_HR;
      SET_HR:  if (mode_btn) state_d = SET_MIN;
      SET_MIN: if (mode_btn) state_d = SET_SEC;
      SET_SEC: if (mode_btn) state_d = AL_HR;
      AL_HR:   if (mode_btn) state_d = AL_MIN;
      AL_MIN:  if (mode_btn) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
    en_d  = (pre_q == PRE_MAX);
    hr_d  = hr_q;
    min_d = min_q;
    sec_d = sec_q;
    alh_d = alh_q;
    alm_d = alm_q;
    if (state_q == RUN) begin
      if (en_q) begin
        hr_d  = hr_nx;
        min_d = min_nx;
        sec_d = sec_nx;
      end
    end else if (inc) begin
      case (state_q)
        SET_HR:  hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        SET_MIN: min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        SET_SEC: begin
          // Restart the second so the next tick lands a full period later.
          sec_d = 6'd0;
          pre_d = '0;
        end
        AL_HR:   alh_d = (alh_q == 5'd23) ? 5'd0 : alh_q + 5'd1;
        AL_MIN:  alm_d = (alm_q == 6'd59) ? 6'd0 : alm_q + 6'd1;
        default: ;
      endcase
    end
  end

  // Cancel beats trigger; a running ring keeps timing out in any state.
  always_comb begin
    ring_d = ring_q;
    rcnt_d = rcnt_q;
    if (cancel) begin
      ring_d = 1'b0;
      rcnt_d = '0;
    end else if (trigger) begin
      ring_d = 1'b1;
      rcnt_d = RING_LD;
    end else if (ring_q && en_q) begin
      rcnt_d = rcnt_q - 1'b1;
      if (rcnt_q <= RW'(1)) ring_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pre_q   <= '0;
      en_q    <= 1'b0;
      hr_q    <= 5'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      alh_q   <= 5'(AL_HOUR_RST);
      alm_q   <= 6'(AL_MIN_RST);
      ring_q  <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      en_q    <= en_d;
      hr_q    <= hr_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      alh_q   <= alh_d;
      alm_q   <= alm_d;
      ring_q  <= ring_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    hour = hr_q;
    if (fmt_12h) begin
      if (hr_q == 5'd0)      hour = 5'd12;
      else if (hr_q > 5'd12) hour = hr_q - 5'd12;
    end
  end

  assign pm         = (hr_q >= 5'd12);
  assign en_1hz     = en_q;
  assign minute     = min_q;
  assign second     = sec_q;
  assign edit_state = state_q;
  assign alarm_hour = alh_q;
  assign alarm_min  = alm_q;
  assign alarm_ring = ring_q;

endmodule
